// File: rtl/uart_resp_pkg.sv
// Shared types and byte constants for the UART command responder.
package uart_resp_pkg;

   typedef enum logic [2:0] {
      WAIT_SYNC,
      GET_CMD,
      GET_ADDR,
      GET_CHK,
      CHECK,
      CAPTURE,
      SEND,
      WAIT_DONE
   } state_t;

   localparam logic [7:0] REQ_SYNC  = 8'hA5;
   localparam logic [7:0] RESP_SYNC = 8'h5A;
   localparam logic [7:0] CMD_READ  = 8'h01;
   localparam logic [7:0] CMD_PING  = 8'h02;

   localparam logic [7:0] STATUS_OK      = 8'h00;
   localparam logic [7:0] STATUS_BADCHK  = 8'h01;
   localparam logic [7:0] STATUS_BADCMD  = 8'h02;
   localparam logic [7:0] STATUS_BADADDR = 8'h03;

   // Index of the last response byte (RCHK); the response is bytes 0..4.
   localparam logic [2:0] LAST_IDX = 3'd4;

endpackage

// File: rtl/uart_cmd_responder.sv
// Parses 4-byte host requests (A5 CMD ADDR CHK), reads the register file and
// answers with a 5-byte frame (5A STATUS D_HI D_LO RCHK) through uart_tx.
module uart_cmd_responder
   import uart_resp_pkg::*;
#(
   parameter int          NUM_REGS       = 16,
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter logic [15:0] PING_WORD      = 16'hC0DE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic        reg_rd,
   output logic [7:0]  reg_addr,
   input  logic [15:0] reg_rdata,
   output logic        busy,
   output logic        frame_err,
   output logic        overrun
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    chk_q, chk_d;
   logic [7:0]    status_q, status_d;
   logic [15:0]   data_q, data_d;
   logic [2:0]    idx_q, idx_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          overrun_q, overrun_d;

   logic [7:0]    check_status;
   logic [7:0]    resp_byte;
   logic [TW-1:0] timer_inc;

   // Classify the captured request; checksum errors take priority over everything else.
   always_comb begin
      check_status = STATUS_OK;
      if ((cmd_q ^ addr_q) != chk_q) begin
         check_status = STATUS_BADCHK;
      end else if ((cmd_q != CMD_READ) && (cmd_q != CMD_PING)) begin
         check_status = STATUS_BADCMD;
      end else if ((cmd_q == CMD_READ) && ({24'd0, addr_q} >= $unsigned(NUM_REGS))) begin
         check_status = STATUS_BADADDR;
      end
   end

   // Select the response byte currently being sent; RCHK is formed on the fly.
   always_comb begin
      case (idx_q)
         3'd0:    resp_byte = RESP_SYNC;
         3'd1:    resp_byte = status_q;
         3'd2:    resp_byte = data_q[15:8];
         3'd3:    resp_byte = data_q[7:0];
         default: resp_byte = status_q ^ data_q[15:8] ^ data_q[7:0];
      endcase
   end

   // Next-state and output decode for the request/response sequencer.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      chk_d     = chk_q;
      status_d  = status_q;
      data_d    = data_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      timer_inc = timer_q + TW'(1);
      tx_start  = 1'b0;
      tx_data   = 8'h00;
      reg_rd    = 1'b0;
      reg_addr  = 8'h00;
      frame_err = 1'b0;
      busy      = (state_q != WAIT_SYNC);
      overrun_d = rx_valid && ((state_q == CHECK) || (state_q == CAPTURE) ||
                               (state_q == SEND)  || (state_q == WAIT_DONE));

      case (state_q)
         WAIT_SYNC: begin
            idx_d   = 3'd0;
            timer_d = '0;
            if (rx_valid && (rx_data == REQ_SYNC)) begin
               state_d = GET_CMD;
            end
         end

         GET_CMD, GET_ADDR, GET_CHK: begin
            if (rx_valid) begin
               timer_d = '0;
               if (state_q == GET_CMD) begin
                  cmd_d   = rx_data;
                  state_d = GET_ADDR;
               end else if (state_q == GET_ADDR) begin
                  addr_d  = rx_data;
                  state_d = GET_CHK;
               end else begin
                  chk_d   = rx_data;
                  state_d = CHECK;
               end
            end else if (timer_inc == TW'(TIMEOUT_CYCLES - 1)) begin
               frame_err = 1'b1;
               timer_d   = '0;
               state_d   = WAIT_SYNC;
            end else begin
               timer_d = timer_inc;
            end
         end

         CHECK: begin
            status_d = check_status;
            data_d   = ((check_status == STATUS_OK) && (cmd_q == CMD_PING)) ? PING_WORD : 16'h0000;
            if (check_status == STATUS_BADCHK) begin
               frame_err = 1'b1;
            end
            if ((check_status == STATUS_OK) && (cmd_q == CMD_READ)) begin
               reg_rd   = 1'b1;
               reg_addr = addr_q;
               state_d  = CAPTURE;
            end else begin
               state_d = SEND;
            end
         end

         CAPTURE: begin
            data_d  = reg_rdata;
            state_d = SEND;
         end

         SEND: begin
            tx_data = resp_byte;
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            tx_data = resp_byte;
            if (tx_done) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = 3'd0;
                  state_d = WAIT_SYNC;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = SEND;
               end
            end
         end

         default: begin
            state_d = WAIT_SYNC;
         end
      endcase
   end

   assign overrun = overrun_q;

   // State and datapath registers; reset abandons any frame or response in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= WAIT_SYNC;
         cmd_q     <= 8'h00;
         addr_q    <= 8'h00;
         chk_q     <= 8'h00;
         status_q  <= 8'h00;
         data_q    <= 16'h0000;
         idx_q     <= 3'd0;
         timer_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         chk_q     <= chk_d;
         status_q  <= status_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         timer_q   <= timer_d;
         overrun_q <= overrun_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with behavioural uart_tx and register file.
module tb_uart_cmd_responder;

   localparam int NUM_REGS = 16;
   localparam int TIMEOUT  = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done = 1'b0;
   logic        reg_rd;
   logic [7:0]  reg_addr;
   logic [15:0] reg_rdata = 16'h0000;
   logic        busy;
   logic        frame_err;
   logic        overrun;

   int checks   = 0;
   int failures = 0;

   uart_cmd_responder #(
      .NUM_REGS       (NUM_REGS),
      .TIMEOUT_CYCLES (TIMEOUT),
      .PING_WORD      (16'hC0DE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .reg_rd    (reg_rd),
      .reg_addr  (reg_addr),
      .reg_rdata (reg_rdata),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural register file: read data appears the cycle after reg_rd.
   logic [15:0] regs [0:NUM_REGS-1];
   always @(posedge clk) begin
      if (reg_rd) reg_rdata <= regs[reg_addr[3:0]];
   end

   // Behavioural uart_tx: busy for 5 cycles per byte, then a one-cycle tx_done.
   logic       mdl_busy   = 1'b0;
   logic       force_busy = 1'b0;
   logic       chk_en     = 1'b0;
   logic [7:0] mdl_byte   = 8'h00;
   int         mdl_cnt    = 0;
   int         stab_err   = 0;
   assign tx_busy = mdl_busy | force_busy;

   always @(posedge clk) begin
      tx_done <= 1'b0;
      if (rst) chk_en <= 1'b0;
      if (mdl_busy) begin
         if (chk_en && !rst && (tx_data !== mdl_byte)) stab_err <= stab_err + 1;
         if (mdl_cnt == 1) begin
            tx_done  <= 1'b1;
            mdl_busy <= 1'b0;
         end
         mdl_cnt <= mdl_cnt - 1;
      end else if (tx_start) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= 5;
         mdl_byte <= tx_data;
         chk_en   <= 1'b1;
      end
   end

   // Event monitor, sampled mid-cycle.
   logic [7:0] tx_q [$];
   int   start_cyc [$];
   int   rd_cnt = 0, fe_cnt = 0, ov_cnt = 0, done_cnt = 0;
   int   fe_cyc = 0, ov_cyc = 0, done_cyc = 0, fall_cyc = 0;
   logic [7:0] rd_addr_last = 8'h00;
   logic busy_prev = 1'b0;

   always @(negedge clk) begin
      if (tx_start) begin
         tx_q.push_back(tx_data);
         start_cyc.push_back(cyc);
      end
      if (reg_rd) begin
         rd_cnt++;
         rd_addr_last = reg_addr;
      end
      if (frame_err) begin
         fe_cnt++;
         fe_cyc = cyc;
      end
      if (overrun) begin
         ov_cnt++;
         ov_cyc = cyc;
      end
      if (tx_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy_prev && !busy) fall_cyc = cyc;
      busy_prev = busy;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation hung");
   end

   int last_rx_cyc = 0;

   // Drive one received byte as a single-cycle rx_valid strobe.
   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clk); #2;
      rx_data     = b;
      rx_valid    = 1'b1;
      last_rx_cyc = cyc;
      @(posedge clk); #2;
      rx_valid = 1'b0;
   endtask

   task automatic clear_log();
      tx_q.delete();
      start_cyc.delete();
   endtask

   // Send a full request and wait (bounded) until the response has drained.
   task automatic run_frame(input logic [7:0] b0, b1, b2, b3, input string name);
      bit idle = 0;
      applyStimulus(b0);
      applyStimulus(b1);
      applyStimulus(b2);
      applyStimulus(b3);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy && !tx_busy) begin
            idle = 1;
            break;
         end
      end
      @(negedge clk);
      checks++;
      if (!idle) begin
         failures++;
         $display("[TB] FAIL %s_idle got=busy exp=idle", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({tx_start, tx_data, reg_rd, reg_addr, busy, frame_err, overrun} !== 21'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%b%h%b%h%b%b%b exp=all zero",
                  tx_start, tx_data, reg_rd, reg_addr, busy, frame_err, overrun);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_read_ok();
      logic [39:0] exp = 40'h5A_00_12_34_26;
      logic [7:0]  got;
      int rd0 = rd_cnt, dn0 = done_cnt, chk_cyc;
      clear_log();
      run_frame(8'hA5, 8'h01, 8'h03, 8'h02, "read_ok");
      chk_cyc = last_rx_cyc;
      checks++;
      if (rd_cnt - rd0 !== 1) begin
         failures++; $display("[TB] FAIL read_ok_rd_count got=%0d exp=1", rd_cnt - rd0);
      end
      checks++;
      if (rd_addr_last !== 8'h03) begin
         failures++; $display("[TB] FAIL read_ok_rd_addr got=%h exp=03", rd_addr_last);
      end
      checks++;
      if (tx_q.size() !== 5) begin
         failures++; $display("[TB] FAIL read_ok_nbytes got=%0d exp=5", tx_q.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
         checks++;
         if (got !== exp[39-8*i -: 8]) begin
            failures++; $display("[TB] FAIL read_ok_byte%0d got=%h exp=%h", i, got, exp[39-8*i -: 8]);
         end
      end
      checks++;
      if ((start_cyc.size() == 0) || (start_cyc[0] - chk_cyc !== 3)) begin
         failures++;
         $display("[TB] FAIL read_ok_latency got=%0d exp=3",
                  (start_cyc.size() == 0) ? -1 : start_cyc[0] - chk_cyc);
      end
      checks++;
      if ((done_cnt - dn0 !== 5) || (fall_cyc !== done_cyc + 1)) begin
         failures++;
         $display("[TB] FAIL read_ok_busy_fall got=dones %0d fall %0d exp=dones 5 fall %0d",
                  done_cnt - dn0, fall_cyc, done_cyc + 1);
      end
   endtask

   task automatic test_bad_checksum();
      logic [39:0] exp = 40'h5A_01_00_00_01;
      logic [7:0]  got;
      int rd0 = rd_cnt, fe0 = fe_cnt, chk_cyc;
      clear_log();
      run_frame(8'hA5, 8'h01, 8'h03, 8'h00, "badchk");
      chk_cyc = last_rx_cyc;
      checks++;
      if ((fe_cnt - fe0 !== 1) || (fe_cyc !== chk_cyc + 1)) begin
         failures++;
         $display("[TB] FAIL badchk_frame_err got=n%0d@%0d exp=n1@%0d", fe_cnt - fe0, fe_cyc, chk_cyc + 1);
      end
      checks++;
      if (rd_cnt !== rd0) begin
         failures++; $display("[TB] FAIL badchk_no_rd got=%0d exp=0", rd_cnt - rd0);
      end
      checks++;
      if ((start_cyc.size() == 0) || (start_cyc[0] - chk_cyc !== 2)) begin
         failures++;
         $display("[TB] FAIL badchk_latency got=%0d exp=2",
                  (start_cyc.size() == 0) ? -1 : start_cyc[0] - chk_cyc);
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
         checks++;
         if (got !== exp[39-8*i -: 8]) begin
            failures++; $display("[TB] FAIL badchk_byte%0d got=%h exp=%h", i, got, exp[39-8*i -: 8]);
         end
      end
   endtask

   task automatic test_bad_cmd_and_ping();
      logic [39:0] exp_cmd  = 40'h5A_02_00_00_02;
      logic [39:0] exp_ping = 40'h5A_00_C0_DE_1E;
      logic [7:0]  got;
      int fe0 = fe_cnt;
      clear_log();
      run_frame(8'hA5, 8'h07, 8'h00, 8'h07, "badcmd");
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
         checks++;
         if (got !== exp_cmd[39-8*i -: 8]) begin
            failures++; $display("[TB] FAIL badcmd_byte%0d got=%h exp=%h", i, got, exp_cmd[39-8*i -: 8]);
         end
      end
      checks++;
      if (fe_cnt !== fe0) begin
         failures++; $display("[TB] FAIL badcmd_no_frame_err got=%0d exp=0", fe_cnt - fe0);
      end
      clear_log();
      run_frame(8'hA5, 8'h02, 8'h00, 8'h02, "ping");
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
         checks++;
         if (got !== exp_ping[39-8*i -: 8]) begin
            failures++; $display("[TB] FAIL ping_byte%0d got=%h exp=%h", i, got, exp_ping[39-8*i -: 8]);
         end
      end
   endtask

   task automatic test_bad_addr();
      logic [39:0] exp = 40'h5A_03_00_00_03;
      logic [7:0]  got;
      int rd0 = rd_cnt;
      clear_log();
      run_frame(8'hA5, 8'h01, 8'h20, 8'h21, "badaddr");
      checks++;
      if (rd_cnt !== rd0) begin
         failures++; $display("[TB] FAIL badaddr_no_rd got=%0d exp=0", rd_cnt - rd0);
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
         checks++;
         if (got !== exp[39-8*i -: 8]) begin
            failures++; $display("[TB] FAIL badaddr_byte%0d got=%h exp=%h", i, got, exp[39-8*i -: 8]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [39:0] exp = 40'h5A_00_BE_EF_51;
      logic [7:0]  got;
      int fe0 = fe_cnt, n;
      clear_log();
      applyStimulus(8'h33);
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      n = last_rx_cyc;
      repeat (TIMEOUT + 20) @(negedge clk);
      checks++;
      if ((fe_cnt - fe0 !== 1) || (fe_cyc - n !== TIMEOUT - 1)) begin
         failures++;
         $display("[TB] FAIL timeout_frame_err got=n%0d dist%0d exp=n1 dist%0d", fe_cnt - fe0, fe_cyc - n, TIMEOUT - 1);
      end
      checks++;
      if ((start_cyc.size() !== 0) || (busy !== 1'b0)) begin
         failures++;
         $display("[TB] FAIL timeout_silent got=starts %0d busy %b exp=starts 0 busy 0", start_cyc.size(), busy);
      end
      clear_log();
      run_frame(8'hA5, 8'h01, 8'h05, 8'h04, "after_timeout");
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
         checks++;
         if (got !== exp[39-8*i -: 8]) begin
            failures++; $display("[TB] FAIL after_timeout_byte%0d got=%h exp=%h", i, got, exp[39-8*i -: 8]);
         end
      end
   endtask

   task automatic test_overrun_busy();
      logic [39:0] exp = 40'h5A_00_C0_DE_1E;
      logic [7:0]  got;
      int ov0 = ov_cnt, rel_cyc, first_cyc = -1, inj;
      bit idle = 0;
      clear_log();
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'h02);
      force_busy = 1'b1;
      repeat (50) @(posedge clk);
      #2;
      checks++;
      if (start_cyc.size() !== 0) begin
         failures++; $display("[TB] FAIL busy_hold_no_start got=%0d exp=0", start_cyc.size());
      end
      force_busy = 1'b0;
      rel_cyc    = cyc;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_start) begin
            first_cyc = cyc;
            break;
         end
      end
      checks++;
      if (first_cyc !== rel_cyc) begin
         failures++; $display("[TB] FAIL busy_release_start got=%0d exp=%0d", first_cyc, rel_cyc);
      end
      @(posedge clk); #2;
      rx_data = 8'h55; rx_valid = 1'b1; inj = cyc;
      @(posedge clk); #2;
      rx_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy && !tx_busy) begin
            idle = 1;
            break;
         end
      end
      checks++;
      if (!idle || (ov_cnt - ov0 !== 1) || (ov_cyc !== inj + 1)) begin
         failures++;
         $display("[TB] FAIL overrun_pulse got=idle%0d n%0d@%0d exp=idle1 n1@%0d", idle, ov_cnt - ov0, ov_cyc, inj + 1);
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
         checks++;
         if (got !== exp[39-8*i -: 8]) begin
            failures++; $display("[TB] FAIL overrun_byte%0d got=%h exp=%h", i, got, exp[39-8*i -: 8]);
         end
      end
      checks++;
      if (stab_err !== 0) begin
         failures++; $display("[TB] FAIL tx_data_stable got=%0d exp=0", stab_err);
      end
   endtask

   task automatic test_reset_mid_response();
      logic [39:0] exp = 40'h5A_00_12_34_26;
      logic [7:0]  got;
      clear_log();
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'h02);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (start_cyc.size() >= 2) break;
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({tx_start, tx_data, reg_rd, reg_addr, busy, frame_err, overrun} !== 21'd0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs got=%b%h%b%h%b%b%b exp=all zero",
                  tx_start, tx_data, reg_rd, reg_addr, busy, frame_err, overrun);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      clear_log();
      run_frame(8'hA5, 8'h01, 8'h03, 8'h02, "after_reset");
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hFF;
         checks++;
         if (got !== exp[39-8*i -: 8]) begin
            failures++; $display("[TB] FAIL after_reset_byte%0d got=%h exp=%h", i, got, exp[39-8*i -: 8]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'h1000 + 16'(i);
      regs[3] = 16'h1234;
      regs[5] = 16'hBEEF;
      test_reset();
      test_read_ok();
      test_bad_checksum();
      test_bad_cmd_and_ping();
      test_bad_addr();
      test_timeout();
      test_overrun_busy();
      test_reset_mid_response();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
